csr_bank: RTL and testbench

//  CSR responder for the DTPU control unit. Holds NUM_REGS 8-bit registers.

---
 rtl/csr_bank.sv | 168 ++++++++++++++++
 tb/tb_csr_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank.sv
// CSR bank shared by the PS host port and the control unit; CU write lock is optional (CSR_LOCK_EN).
// Both read ports have 1-cycle registered latency; no backpressure, every access completes in one cycle.
module csr_bank #(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32,
    parameter int NUM_REGS         = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        csr_ce,
    input  logic                        csr_we,
    input  logic [ADDRESS_SIZE_CSR-1:0] csr_address,
    input  logic [DATA_WIDTH_CSR-1:0]   csr_din,
    output logic [DATA_WIDTH_CSR-1:0]   csr_dout,
    input  logic                        csr_reset,
    input  logic                        host_wr_en,
    input  logic                        host_rd_en,
    input  logic [ADDRESS_SIZE_CSR-1:0] host_addr,
    input  logic [DATA_WIDTH_CSR-1:0]   host_wdata,
    output logic [DATA_WIDTH_CSR-1:0]   host_rdata,
    output logic                        host_rvalid,
    input  logic                        cs_done,
    input  logic                        cs_idle,
    input  logic                        cs_ready
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDRESS_SIZE_CSR-1:0] REG_LIMIT = ADDRESS_SIZE_CSR'(NUM_REGS);
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CFG0   = IDX_W'(2);

    logic [DATA_WIDTH_CSR-1:0] ctrl_q;
    logic [DATA_WIDTH_CSR-1:0] cfg_q [2:NUM_REGS-1];
    logic                      done_q;
    logic                      idle_q;
    logic                      ready_q;
    logic                      addr_err_q;
    logic                      lock_viol_q;

    logic [DATA_WIDTH_CSR-1:0] status_val;
    logic [DATA_WIDTH_CSR-1:0] reg_view [NUM_REGS];
    logic [DATA_WIDTH_CSR-1:0] cu_rd_val;
    logic [DATA_WIDTH_CSR-1:0] host_rd_val;

    logic             cu_in_range;
    logic             host_in_range;
    logic [IDX_W-1:0] cu_idx;
    logic [IDX_W-1:0] host_idx;
    logic             cu_rd;
    logic             cu_wr_cfg;
    logic             cu_blocked;
    logic             cu_cfg_en;
    logic             host_wr;
    logic             status_wr;
    logic             addr_err_ev;
    logic             lock_viol_ev;
    logic             clr_done;
    logic             clr_addr_err;
    logic             clr_lock_viol;

    // Full-width compare: an address aliasing onto a valid index is still an error.
    assign cu_in_range   = csr_address < REG_LIMIT;
    assign host_in_range = host_addr < REG_LIMIT;
    assign cu_idx        = csr_address[IDX_W-1:0];
    assign host_idx      = host_addr[IDX_W-1:0];

    assign cu_rd     = csr_ce & ~csr_we;
    assign cu_wr_cfg = csr_ce & csr_we & cu_in_range & (cu_idx >= IDX_CFG0);
    assign host_wr   = host_wr_en & host_in_range;
    assign status_wr = host_wr & (host_idx == IDX_STATUS);

`ifdef CSR_LOCK_EN
    assign cu_blocked = ctrl_q[DATA_WIDTH_CSR-1];
`else
    assign cu_blocked = 1'b0;
`endif

    assign cu_cfg_en    = cu_wr_cfg & ~cu_blocked;
    assign lock_viol_ev = cu_wr_cfg & cu_blocked;
    assign addr_err_ev  = (csr_ce & ~cu_in_range)
                        | ((host_wr_en | host_rd_en) & ~host_in_range);

    assign clr_done      = status_wr & host_wdata[0];
    assign clr_addr_err  = status_wr & host_wdata[3];
    assign clr_lock_viol = status_wr & host_wdata[4];

    always_comb begin
        status_val    = '0;
        status_val[0] = done_q;
        status_val[1] = idle_q;
        status_val[2] = ready_q;
        status_val[3] = addr_err_q;
        status_val[4] = lock_viol_q;
    end

    always_comb begin
        reg_view[0] = ctrl_q;
        reg_view[1] = status_val;
        for (int i = 2; i < NUM_REGS; i++) begin
            reg_view[i] = cfg_q[i];
        end
    end

    assign cu_rd_val   = cu_in_range   ? reg_view[cu_idx]   : '0;
    assign host_rd_val = host_in_range ? reg_view[host_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else if (host_wr && (host_idx == IDX_CTRL)) begin
            ctrl_q <= host_wdata;
        end
    end

    // csr_reset beats both writers; PS beats CU on a same-register collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (csr_reset) begin
                    cfg_q[i] <= '0;
                end else if (host_wr && (host_idx == IDX_W'(i))) begin
                    cfg_q[i] <= host_wdata;
                end else if (cu_cfg_en && (cu_idx == IDX_W'(i))) begin
                    cfg_q[i] <= csr_din;
                end
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a W1C wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= 1'b0;
            idle_q      <= 1'b0;
            ready_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            lock_viol_q <= 1'b0;
        end else begin
            done_q      <= cs_done      | (done_q      & ~clr_done);
            addr_err_q  <= addr_err_ev  | (addr_err_q  & ~clr_addr_err);
            lock_viol_q <= lock_viol_ev | (lock_viol_q & ~clr_lock_viol);
            idle_q      <= cs_idle;
            ready_q     <= cs_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_dout    <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            if (cu_rd) begin
                csr_dout <= cu_rd_val;
            end
            if (host_rd_en) begin
                host_rdata <= host_rd_val;
            end
            host_rvalid <= host_rd_en;
        end
    end

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: directed vector table, reset-mid-access sequence, then random traffic vs a reference model.
module tb_csr_bank;

    localparam int N = 16;
`ifdef CSR_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    localparam logic [7:0] R4_EXP = LOCK ? 8'h00 : 8'h5A;
    localparam logic [7:0] LV     = LOCK ? 8'h10 : 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_ce, csr_we, csr_reset;
    logic [31:0] csr_address, host_addr;
    logic [7:0]  csr_din, csr_dout, host_wdata, host_rdata;
    logic        host_wr_en, host_rd_en, host_rvalid;
    logic        cs_done, cs_idle, cs_ready;

    int n_tests = 0;
    int n_fail  = 0;

    csr_bank dut (
        .clk(clk), .reset(reset),
        .csr_ce(csr_ce), .csr_we(csr_we), .csr_address(csr_address),
        .csr_din(csr_din), .csr_dout(csr_dout), .csr_reset(csr_reset),
        .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .cs_done(cs_done), .cs_idle(cs_idle), .cs_ready(cs_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        csr_ce = 0; csr_we = 0; csr_address = 0; csr_din = 0; csr_reset = 0;
        host_wr_en = 0; host_rd_en = 0; host_addr = 0; host_wdata = 0;
        cs_done = 0; cs_idle = 0; cs_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        hw, hr;
        logic [31:0] ha;
        logic [7:0]  hd;
        logic        ce, we;
        logic [31:0] ca;
        logic [7:0]  cd;
        logic [2:0]  st;     // {ready, idle, done}
        logic        crst;
        logic [7:0]  e_cdout;
        logic        e_rv;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic hw, logic hr, logic [31:0] ha, logic [7:0] hd,
                                logic ce, logic we, logic [31:0] ca, logic [7:0] cd,
                                logic [2:0] st, logic crst,
                                logic [7:0] e_cdout, logic e_rv, logic [7:0] e_rdata);
        vec_t v;
        v.hw = hw; v.hr = hr; v.ha = ha; v.hd = hd;
        v.ce = ce; v.we = we; v.ca = ca; v.cd = cd;
        v.st = st; v.crst = crst;
        v.e_cdout = e_cdout; v.e_rv = e_rv; v.e_rdata = e_rdata;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] m_reg [N];
    logic       m_done, m_err, m_lock, m_idle, m_ready;
    logic [7:0] exp_cdout, exp_rdata;
    logic       exp_rv;

    function automatic logic [7:0] m_read(logic [31:0] a);
        if (a >= N) return 8'h00;
        if (a == 1) return {3'b000, m_lock, m_err, m_ready, m_idle, m_done};
        return m_reg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = 8'h00;
        m_done = 0; m_err = 0; m_lock = 0; m_idle = 0; m_ready = 0;
        exp_cdout = 8'h00; exp_rdata = 8'h00; exp_rv = 0;
    endtask

    task automatic model_cycle();
        logic [7:0] nxt [N];
        logic [7:0] w1c;
        logic       err_ev, lock_ev;
        for (int i = 0; i < N; i++) nxt[i] = m_reg[i];
        if (csr_ce && !csr_we) exp_cdout = m_read(csr_address);
        exp_rv = host_rd_en;
        if (host_rd_en) exp_rdata = m_read(host_addr);
        err_ev  = (csr_ce && csr_address >= N) || ((host_wr_en || host_rd_en) && host_addr >= N);
        lock_ev = 0;
        if (csr_ce && csr_we && csr_address >= 2 && csr_address < N) begin
            if (LOCK && m_reg[0][7]) lock_ev = 1;
            else nxt[csr_address] = csr_din;
        end
        if (host_wr_en && host_addr < N && host_addr != 1) nxt[host_addr] = host_wdata;
        if (csr_reset) for (int i = 2; i < N; i++) nxt[i] = 8'h00;
        w1c     = (host_wr_en && host_addr == 1) ? host_wdata : 8'h00;
        m_done  = cs_done | (m_done & ~w1c[0]);
        m_err   = err_ev  | (m_err  & ~w1c[3]);
        m_lock  = lock_ev | (m_lock & ~w1c[4]);
        m_idle  = cs_idle;
        m_ready = cs_ready;
        for (int i = 0; i < N; i++) m_reg[i] = nxt[i];
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        case (r)
            16:      return 32'd16;
            17:      return 32'h100;
            18:      return 32'hFFFF_FFFF;
            19:      return 32'h8000_0002;
            default: return r;
        endcase
    endfunction

    initial begin
        reset = 0;
        idle_inputs();
        #2;
        chk("reset_csr_dout",    csr_dout,    0);
        chk("reset_host_rvalid", host_rvalid, 0);
        chk("reset_host_rdata",  host_rdata,  0);
        do_reset();

        vecs.push_back(mk(1,0,2,8'hFE,      0,0,0,0,        3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,0,0,0,          1,0,2,0,        3'b000,0, 8'hFE,0,8'h00));
        vecs.push_back(mk(1,0,3,8'h11,      1,1,3,8'h22,    3'b000,0, 8'hFE,0,8'h00));
        vecs.push_back(mk(0,1,3,0,          0,0,0,0,        3'b000,0, 8'hFE,1,8'h11));
        vecs.push_back(mk(0,0,0,0,          1,0,32'h100,0,  3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b000,0, 8'h00,1,8'h08));
        vecs.push_back(mk(1,0,1,8'h08,      0,0,0,0,        3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b000,0, 8'h00,1,8'h00));
        vecs.push_back(mk(1,0,1,8'h01,      0,0,0,0,        3'b001,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b000,0, 8'h00,1,8'h01));
        vecs.push_back(mk(1,0,1,8'h01,      0,0,0,0,        3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b110,0, 8'h00,1,8'h00));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b110,0, 8'h00,1,8'h06));
        vecs.push_back(mk(1,0,0,8'h80,      0,0,0,0,        3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,0,0,0,          1,1,4,8'h5A,    3'b000,0, 8'h00,0,8'h00));
        vecs.push_back(mk(0,1,4,0,          0,0,0,0,        3'b000,0, 8'h00,1,R4_EXP));
        vecs.push_back(mk(0,1,1,0,          0,0,0,0,        3'b000,0, 8'h00,1,LV));
        vecs.push_back(mk(0,0,0,0,          1,0,0,0,        3'b000,0, 8'h80,0,8'h00));
        vecs.push_back(mk(1,0,2,8'h77,      0,0,0,0,        3'b000,1, 8'h80,0,8'h00));
        vecs.push_back(mk(0,1,0,0,          1,0,2,0,        3'b000,0, 8'h00,1,8'h80));
        vecs.push_back(mk(1,1,5,8'h33,      0,0,0,0,        3'b000,0, 8'h00,1,8'h00));
        vecs.push_back(mk(1,0,5,8'h55,      1,0,5,0,        3'b000,0, 8'h33,0,8'h00));
        vecs.push_back(mk(0,0,0,0,          1,0,5,0,        3'b000,0, 8'h55,0,8'h00));
        vecs.push_back(mk(1,0,16,8'h99,     0,0,0,0,        3'b000,0, 8'h55,0,8'h00));
        vecs.push_back(mk(0,1,0,0,          1,0,1,0,        3'b000,0, 8'h08|LV,1,8'h80));
        vecs.push_back(mk(0,0,0,0,          1,1,0,8'h01,    3'b000,0, 8'h08|LV,0,8'h00));
        vecs.push_back(mk(0,0,0,0,          1,0,0,0,        3'b000,0, 8'h80,0,8'h00));
        vecs.push_back(mk(1,0,1,8'h1E,      0,0,0,0,        3'b000,0, 8'h80,0,8'h00));
        vecs.push_back(mk(0,0,0,0,          1,0,1,0,        3'b000,0, 8'h00,0,8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            host_wr_en = vecs[i].hw; host_rd_en = vecs[i].hr;
            host_addr  = vecs[i].ha; host_wdata = vecs[i].hd;
            csr_ce = vecs[i].ce; csr_we = vecs[i].we;
            csr_address = vecs[i].ca; csr_din = vecs[i].cd;
            cs_done = vecs[i].st[0]; cs_idle = vecs[i].st[1]; cs_ready = vecs[i].st[2];
            csr_reset = vecs[i].crst;
            step();
            chk($sformatf("vec%0d_csr_dout", i), csr_dout, vecs[i].e_cdout);
            chk($sformatf("vec%0d_rvalid", i), host_rvalid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("vec%0d_rdata", i), host_rdata, vecs[i].e_rdata);
        end
        idle_inputs();

        // Reset asserted mid-access: outputs drop immediately, all registers clear.
        host_wr_en = 1; host_addr = 6; host_wdata = 8'hA5;
        step();
        idle_inputs();
        csr_ce = 1; csr_address = 6; host_rd_en = 1; host_addr = 6; cs_done = 1; cs_idle = 1;
        step();
        chk("pre_reset_csr_dout", csr_dout, 8'hA5);
        chk("pre_reset_rvalid",   host_rvalid, 1);
        #3 reset = 0;
        #1;
        chk("midreset_csr_dout",   csr_dout,    0);
        chk("midreset_host_rvalid", host_rvalid, 0);
        chk("midreset_host_rdata",  host_rdata,  0);
        @(negedge clk);
        idle_inputs();
        reset = 1;
        for (int i = 0; i < N; i++) begin
            host_rd_en = 1; host_addr = i;
            step();
            chk($sformatf("post_reset_reg%0d", i), host_rdata, 8'h00);
        end
        idle_inputs();

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            csr_ce      = 1'($urandom_range(0, 1));
            csr_we      = 1'($urandom_range(0, 1));
            csr_address = rand_addr();
            csr_din     = 8'($urandom);
            host_wr_en  = ($urandom_range(0, 2) == 0);
            host_rd_en  = 1'($urandom_range(0, 1));
            host_addr   = rand_addr();
            host_wdata  = 8'($urandom);
            csr_reset   = ($urandom_range(0, 15) == 0);
            cs_done     = ($urandom_range(0, 3) == 0);
            cs_idle     = 1'($urandom_range(0, 1));
            cs_ready    = 1'($urandom_range(0, 1));
            model_cycle();
            step();
            chk($sformatf("rnd%0d_csr_dout", c), csr_dout, exp_cdout);
            chk($sformatf("rnd%0d_rvalid", c), host_rvalid, exp_rv);
            if (exp_rv) chk($sformatf("rnd%0d_rdata", c), host_rdata, exp_rdata);
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
